// File: rtl/msdap_output_serializer_if.sv
// -----------------------------------------------------------------------------
// msdap_output_serializer_if
//
// Purpose: groups the parallel load handshake and the serial output bus of the
// MSDAP output serializer.
//
// Signals:
//   load_valid    producer -> serializer, dataL/dataR valid this cycle
//   load_ready    serializer -> producer, holding register empty
//   dataL, dataR  WIDTH-bit left/right channel results
//   OutputL/R     serial bits, MSB first
//   OutReady      high while a word is on the serial lines
//   tx_done       one-cycle pulse coincident with the LSB
//
// Modports: master (producer / testbench side), slave (serializer side).
// -----------------------------------------------------------------------------
interface msdap_output_serializer_if #(
    parameter int WIDTH = 40
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] dataL;
    logic [WIDTH-1:0] dataR;
    logic             OutputL;
    logic             OutputR;
    logic             OutReady;
    logic             tx_done;

    modport master (
        output load_valid,
        output dataL,
        output dataR,
        input  load_ready,
        input  OutputL,
        input  OutputR,
        input  OutReady,
        input  tx_done
    );

    modport slave (
        input  load_valid,
        input  dataL,
        input  dataR,
        output load_ready,
        output OutputL,
        output OutputR,
        output OutReady,
        output tx_done
    );
endinterface

// File: rtl/msdap_output_serializer.sv
// -----------------------------------------------------------------------------
// msdap_output_serializer
//
// Purpose: parallel-to-serial output stage for the stereo datapath. One
// left/right pair is accepted per handshake into a one-entry holding register
// and shifted out MSB-first, one bit per SCLK cycle, on OutputL/OutputR with
// OutReady framing the word. The holding register allows back-to-back words
// with no OutReady gap.
//
// Ports:
//   SCLK         system clock, rising edge
//   rst_n        synchronous active-low reset (priority over clear)
//   clear        synchronous abort: flushes holding register and shifter
//   frame_pulse  frame marker, only used with MSDAP_TX_FRAME_SYNC_EN
//   bus          slave modport of msdap_output_serializer_if
//
// Configuration:
//   MSDAP_TX_FRAME_SYNC_EN  when defined, every word start (including
//                           back-to-back starts) waits for frame_pulse in the
//                           WAIT_SYNC state. Undefined: words start as soon as
//                           the holding register is full and the shifter free.
//
// All outputs come straight from flops; their next values are derived from the
// next-state of the FSM and datapath, so there is no input-to-output path.
// -----------------------------------------------------------------------------
module msdap_output_serializer #(
    parameter int WIDTH = 40
) (
    input  logic                     SCLK,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     frame_pulse,
    msdap_output_serializer_if.slave bus
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

`ifdef MSDAP_TX_FRAME_SYNC_EN
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SYNC = 2'd1,
        SHIFT     = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd2
    } state_t;
`endif

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sh_l_q, sh_l_d;
    logic [WIDTH-1:0]   sh_r_q, sh_r_d;
    logic [WIDTH-1:0]   hold_l_q, hold_l_d;
    logic [WIDTH-1:0]   hold_r_q, hold_r_d;
    logic               hold_full_q, hold_full_d;

    logic               out_l_q, out_l_d;
    logic               out_r_q, out_r_d;
    logic               out_rdy_q, out_rdy_d;
    logic               tx_done_q, tx_done_d;
    logic               load_ready_q, load_ready_d;

    logic               xfer_s;      // holding register moves into the shifters
    logic               shift_s;     // shifters advance by one bit
    logic               accept_s;    // load handshake completes this edge
    logic               start_ok_s;  // a new word may start on this edge

`ifdef MSDAP_TX_FRAME_SYNC_EN
    assign start_ok_s = frame_pulse;
`else
    logic unused_frame_pulse_s;
    assign unused_frame_pulse_s = frame_pulse;
    assign start_ok_s           = 1'b1;
`endif

    // FSM next-state: word start, shift progress and end-of-word decision.
    always_comb begin
        state_d = state_q;
        xfer_s  = 1'b0;
        shift_s = 1'b0;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hold_full_q) begin
`ifdef MSDAP_TX_FRAME_SYNC_EN
                        state_d = WAIT_SYNC;
`else
                        state_d = SHIFT;
                        xfer_s  = 1'b1;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
`ifdef MSDAP_TX_FRAME_SYNC_EN
                WAIT_SYNC: begin
                    if (frame_pulse) begin
                        state_d = SHIFT;
                        xfer_s  = 1'b1;
                    end else begin
                        state_d = WAIT_SYNC;
                    end
                end
`endif
                SHIFT: begin
                    if (cnt_q == LAST_BIT) begin
                        // Only a word already held before this edge can chain
                        // on without a gap; a load landing now waits.
                        if (hold_full_q && start_ok_s) begin
                            state_d = SHIFT;
                            xfer_s  = 1'b1;
`ifdef MSDAP_TX_FRAME_SYNC_EN
                        end else if (hold_full_q) begin
                            state_d = WAIT_SYNC;
`endif
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        state_d = SHIFT;
                        shift_s = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Holding register: capture on handshake, drain on transfer, flush on clear.
    always_comb begin
        hold_full_d = hold_full_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        accept_s    = bus.load_valid & ~hold_full_q & ~clear;
        if (clear) begin
            hold_full_d = 1'b0;
        end else if (xfer_s) begin
            hold_full_d = 1'b0;
        end else if (accept_s) begin
            hold_full_d = 1'b1;
            hold_l_d    = bus.dataL;
            hold_r_d    = bus.dataR;
        end else begin
            hold_full_d = hold_full_q;
        end
    end

    // Shifters and bit counter; the counter restarts at 0 on every transfer.
    always_comb begin
        sh_l_d = sh_l_q;
        sh_r_d = sh_r_q;
        cnt_d  = cnt_q;
        if (clear) begin
            sh_l_d = {WIDTH{1'b0}};
            sh_r_d = {WIDTH{1'b0}};
            cnt_d  = {CNT_W{1'b0}};
        end else if (xfer_s) begin
            sh_l_d = hold_l_q;
            sh_r_d = hold_r_q;
            cnt_d  = {CNT_W{1'b0}};
        end else if (shift_s) begin
            sh_l_d = {sh_l_q[WIDTH-2:0], 1'b0};
            sh_r_d = {sh_r_q[WIDTH-2:0], 1'b0};
            cnt_d  = cnt_q + CNT_W'(1);
        end else begin
            sh_l_d = sh_l_q;
            sh_r_d = sh_r_q;
            cnt_d  = cnt_q;
        end
    end

    // Output flop inputs, decoded from the next state so outputs stay registered.
    always_comb begin
        out_l_d      = 1'b0;
        out_r_d      = 1'b0;
        out_rdy_d    = 1'b0;
        tx_done_d    = 1'b0;
        load_ready_d = ~hold_full_d;
        if (state_d == SHIFT) begin
            out_l_d   = sh_l_d[WIDTH-1];
            out_r_d   = sh_r_d[WIDTH-1];
            out_rdy_d = 1'b1;
            tx_done_d = (cnt_d == LAST_BIT);
        end else begin
            out_l_d   = 1'b0;
            out_r_d   = 1'b0;
            out_rdy_d = 1'b0;
            tx_done_d = 1'b0;
        end
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge SCLK) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            sh_l_q       <= {WIDTH{1'b0}};
            sh_r_q       <= {WIDTH{1'b0}};
            hold_l_q     <= {WIDTH{1'b0}};
            hold_r_q     <= {WIDTH{1'b0}};
            hold_full_q  <= 1'b0;
            out_l_q      <= 1'b0;
            out_r_q      <= 1'b0;
            out_rdy_q    <= 1'b0;
            tx_done_q    <= 1'b0;
            load_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sh_l_q       <= sh_l_d;
            sh_r_q       <= sh_r_d;
            hold_l_q     <= hold_l_d;
            hold_r_q     <= hold_r_d;
            hold_full_q  <= hold_full_d;
            out_l_q      <= out_l_d;
            out_r_q      <= out_r_d;
            out_rdy_q    <= out_rdy_d;
            tx_done_q    <= tx_done_d;
            load_ready_q <= load_ready_d;
        end
    end

    assign bus.OutputL    = out_l_q;
    assign bus.OutputR    = out_r_q;
    assign bus.OutReady   = out_rdy_q;
    assign bus.tx_done    = tx_done_q;
    assign bus.load_ready = load_ready_q;

endmodule

// File: tb/tb_msdap_output_serializer.sv
// -----------------------------------------------------------------------------
// tb_msdap_output_serializer
//
// Directed bench for msdap_output_serializer (WIDTH = 40). Inputs change and
// outputs are sampled on the falling edge of SCLK; "edge e" below is the
// rising edge counted from the edge that accepts the first word of a sequence.
// -----------------------------------------------------------------------------
module tb_msdap_output_serializer;

    localparam int WIDTH = 40;

    logic SCLK;
    logic rst_n;
    logic clear;
    logic frame_pulse;

    msdap_output_serializer_if #(.WIDTH(WIDTH)) bus ();

    msdap_output_serializer #(.WIDTH(WIDTH)) dut (
        .SCLK        (SCLK),
        .rst_n       (rst_n),
        .clear       (clear),
        .frame_pulse (frame_pulse),
        .bus         (bus)
    );

    int checks_cnt = 0;
    int errors_cnt = 0;

    initial SCLK = 1'b0;
    always #5 SCLK = ~SCLK;

    // Count one comparison and report it if observed differs from expected.
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge SCLK);
        @(negedge SCLK);
    endtask

    function automatic logic [3:0] out_vec();
        return {bus.OutReady, bus.OutputL, bus.OutputR, bus.tx_done};
    endfunction

    // Word A loaded at edge 0, optional word B at edge b_edge, optional
    // clear (and optionally reset) at abort_edge. Expectations by hand:
    // A bits after edges 1..40, B bits after 41..80, idle after an abort.
    task automatic seq_check(input string name,
                             input logic [WIDTH-1:0] al, input logic [WIDTH-1:0] ar,
                             input logic [WIDTH-1:0] bl, input logic [WIDTH-1:0] br,
                             input int b_edge, input int abort_edge,
                             input bit use_rst, input int last_e);
        logic [3:0] exp_v;
        logic       exp_rdy;
        for (int e = 0; e <= last_e; e++) begin
            bus.load_valid = (e == 0) || (e == b_edge) || (e == abort_edge);
            bus.dataL      = (e == 0) ? al : bl;
            bus.dataR      = (e == 0) ? ar : br;
            clear          = (e == abort_edge);
            rst_n          = !(use_rst && (e == abort_edge));
            tick();
            bus.load_valid = 1'b0;
            clear          = 1'b0;
            rst_n          = 1'b1;
            if (abort_edge >= 0 && e >= abort_edge) begin
                exp_v   = 4'b0000;
                exp_rdy = 1'b1;
            end else begin
                if (e >= 1 && e <= 40)
                    exp_v = {1'b1, al[40-e], ar[40-e], (e == 40)};
                else if (b_edge >= 0 && e >= 41 && e <= 80)
                    exp_v = {1'b1, bl[80-e], br[80-e], (e == 80)};
                else
                    exp_v = 4'b0000;
                exp_rdy = !((e == 0) || (b_edge >= 0 && e >= b_edge && e <= 40));
            end
            chk($sformatf("%s_out_e%0d", name, e), {60'd0, out_vec()}, {60'd0, exp_v});
            chk($sformatf("%s_rdy_e%0d", name, e), {63'd0, bus.load_ready}, {63'd0, exp_rdy});
        end
    endtask

    // load_valid held high for five alternating words: accepts at edges
    // 0, 2, 42, 82, 122; output words back to back over edges 1..200.
    task automatic stream5_check();
        logic [WIDTH-1:0] wl [5];
        logic [WIDTH-1:0] wr [5];
        logic [3:0]       exp_v;
        int               widx;
        int               w;
        int               b;
        for (int i = 0; i < 5; i++) begin
            wl[i] = (i % 2 == 0) ? 40'hAA_AAAA_AAAA : 40'h55_5555_5555;
            wr[i] = (i % 2 == 0) ? 40'h55_5555_5555 : 40'hAA_AAAA_AAAA;
        end
        for (int e = 0; e <= 201; e++) begin
            if (e == 0)       widx = 0;
            else if (e <= 2)  widx = 1;
            else if (e <= 42) widx = 2;
            else if (e <= 82) widx = 3;
            else              widx = 4;
            bus.load_valid = (e <= 122);
            bus.dataL      = wl[widx];
            bus.dataR      = wr[widx];
            tick();
            if (e >= 1 && e <= 200) begin
                w     = (e - 1) / 40;
                b     = 39 - ((e - 1) % 40);
                exp_v = {1'b1, wl[w][b], wr[w][b], (b == 0)};
            end else begin
                exp_v = 4'b0000;
            end
            chk($sformatf("str5_out_e%0d", e), {60'd0, out_vec()}, {60'd0, exp_v});
        end
        bus.load_valid = 1'b0;
    endtask

`ifdef MSDAP_TX_FRAME_SYNC_EN
    // A at edge 0 waits for frame_pulse at edge 10; B (edge 15) waits for
    // the next frame_pulse at edge 60 with OutReady low in between.
    task automatic frame_sync_check();
        logic [WIDTH-1:0] al;
        logic [WIDTH-1:0] bl;
        logic [3:0]       exp_v;
        al = 40'h80_0000_0001;
        bl = 40'hC3_5A00_FF01;
        for (int e = 0; e <= 101; e++) begin
            bus.load_valid = (e == 0) || (e == 15);
            bus.dataL      = (e == 0) ? al : bl;
            bus.dataR      = (e == 0) ? al : bl;
            frame_pulse    = (e == 10) || (e == 60);
            tick();
            bus.load_valid = 1'b0;
            frame_pulse    = 1'b0;
            if (e >= 10 && e <= 49)
                exp_v = {1'b1, al[49-e], al[49-e], (e == 49)};
            else if (e >= 60 && e <= 99)
                exp_v = {1'b1, bl[99-e], bl[99-e], (e == 99)};
            else
                exp_v = 4'b0000;
            chk($sformatf("sync_out_e%0d", e), {60'd0, out_vec()}, {60'd0, exp_v});
        end
    endtask
`endif

    initial begin
        rst_n          = 1'b0;
        clear          = 1'b0;
        frame_pulse    = 1'b0;
        bus.load_valid = 1'b0;
        bus.dataL      = 40'h00_0000_0000;
        bus.dataR      = 40'h00_0000_0000;
        tick();
        tick();
        chk("reset_out", {60'd0, out_vec()}, 64'd0);
        chk("reset_rdy", {63'd0, bus.load_ready}, 64'd1);
        rst_n = 1'b1;
        tick();
        chk("idle_out", {60'd0, out_vec()}, 64'd0);

`ifdef MSDAP_TX_FRAME_SYNC_EN
        frame_sync_check();
`else
        // single word, IDLE start
        seq_check("single", 40'h80_0000_0001, 40'h00_0000_0003,
                  40'h00_0000_0000, 40'h00_0000_0000, -1, -1, 1'b0, 41);
        tick();
        // back-to-back: second load during the first word's shift
        seq_check("b2b", 40'h80_0000_0001, 40'h00_0000_0003,
                  40'hC3_5A00_FF01, 40'h12_3456_789A, 6, -1, 1'b0, 81);
        tick();
        // clear at bit 17 with the holding register full, load dropped
        seq_check("clear", 40'hF0_F0F0_F0F1, 40'h0F_0F0F_0F0E,
                  40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF, 6, 19, 1'b0, 65);
        // reset mid-word with clear also high
        seq_check("rst", 40'hDE_ADBE_EF01, 40'h01_2345_6789,
                  40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF, 6, 10, 1'b1, 55);
        // five continuous words
        stream5_check();
`endif

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/msdap_output_serializer.md
# msdap_output_serializer

Parallel-to-serial output stage for the stereo processor datapath. Accepts one left/right result pair per handshake and shifts both channels out MSB-first on SCLK, one bit per cycle, with OutReady framing each word. A one-entry holding register lets the filter core hand over the next pair while the current one is still shifting, which gives gap-free back-to-back output.

## Interface
- WIDTH, 40: bits per channel word; legal range 2..64
- SCLK  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset is synchronous and active-low
- clear  in  1  synchronous abort; flushes holding register and shifter
- load_valid  in  1  dataL/dataR valid this cycle
- load_ready  out  1  holding register empty; transfer occurs when load_valid & load_ready
- dataL  in  WIDTH  left-channel result
- dataR  in  WIDTH  right-channel result
- frame_pulse  in  1  one-cycle SCLK-domain frame marker (used only with MSDAP_TX_FRAME_SYNC_EN)
- OutputL  out  1  left serial bit
- OutputR  out  1  right serial bit
- OutReady  out  1  high for exactly WIDTH consecutive cycles per word
- tx_done  out  1  one-cycle pulse on the cycle the LSB is presented

## Operation
- Holding register hold_L/hold_R with flag hold_full. load_ready = ~hold_full. An accepted load sets hold_full at the next edge. While hold_full is set, load_valid is ignored.
- States: IDLE, WAIT_SYNC (macro builds only), SHIFT.
- IDLE: outputs 0. If hold_full, the next edge moves hold into the shifters, clears hold_full, loads bit counter = 0, and enters SHIFT. In macro builds it enters WAIT_SYNC instead.
- WAIT_SYNC: on an edge where frame_pulse = 1, performs the same transfer and enters SHIFT.
- SHIFT: OutputL/OutputR = shifter MSB and OutReady = 1. Each edge left-shifts the shifters (zero fill) and increments the counter. tx_done = 1 while counter == WIDTH-1.
- End of word, at the edge leaving counter == WIDTH-1:
  - If hold_full and start is permitted, transfer immediately and stay in SHIFT with counter = 0. There is no OutReady gap.
  - Otherwise go to IDLE, or to WAIT_SYNC if hold_full in a macro build.
  - "Start is permitted" is always true without the macro. With the macro it means frame_pulse = 1 on that edge.
- A load accepted on the same edge that the shifter empties is not eligible for that transfer, because hold_full was not yet set. It starts on a later edge.
- Counter is $clog2(WIDTH) bits and never wraps past WIDTH-1.
- clear = 1 at an edge: hold_full = 0, state = IDLE, counter = 0, and all serial outputs = 0 from the following cycle. Any word in flight is truncated and tx_done is not issued. A load_valid present in the same cycle is dropped.
- rst_n = 0 has priority over clear and has the same effect.

## Timing
- Reset values after an edge with rst_n = 0:
  - OutputL = 0, OutputR = 0, OutReady = 0, tx_done = 0
  - load_ready = 1, hold_full = 0, state = IDLE
- All outputs are registered or decoded from registered state only. There are no combinational paths from inputs to outputs.
- Latency without the macro, from an IDLE start:
  - Load accepted at edge k.
  - MSB appears with OutReady = 1 after edge k+1.
  - LSB and tx_done appear after edge k+WIDTH.
  - OutReady falls after edge k+WIDTH+1 unless a back-to-back transfer occurs.
- Throughput is one word pair per WIDTH cycles. load_ready reasserts the cycle after the holding register drains into the shifter.

## Configuration
- MSDAP_TX_FRAME_SYNC_EN defined:
  - WAIT_SYNC is built.
  - Every word start, including back-to-back starts, is gated by frame_pulse.
  - Output words stay aligned to input frames.
- MSDAP_TX_FRAME_SYNC_EN undefined:
  - WAIT_SYNC is not built and frame_pulse is unused.
  - Words start as soon as the holding register is full and the shifter is free.

## Test plan
- Reset with WIDTH = 40 → all outputs 0 and load_ready = 1. Load L = 40'h80_0000_0001, R = 40'h00_0000_0003 at edge k, no macro → OutputL = 1 after k+1, then 38 zeros, then 1. OutputR is 38 zeros then 1,1. OutReady is high for exactly 40 cycles; tx_done pulses once, coincident with the LSB.
- Second load accepted during the first word's shift → load_ready drops for the whole wait. OutReady stays high for 80 contiguous cycles and the second word's MSB follows the first word's LSB with no gap.
- clear asserted at bit 17 of a word with hold_full = 1 → next cycle OutReady = 0, outputs 0, load_ready = 1, no tx_done. The held word is never transmitted.
- load_valid held high continuously for 5 words with alternating patterns (L = 40'hAA_AAAA_AAAA, L = 40'h55_5555_5555) → 200 contiguous OutReady cycles and bit-exact serial streams.
- Macro build: load at k, frame_pulse at k+10 → OutReady rises the cycle after k+10. A back-to-back word waits for the next frame_pulse, and OutReady stays low until it arrives.
- rst_n low for one edge mid-word with clear also high → reset values exactly as listed in Timing.
